// File: rtl/window_gen_3x3_pkg.sv
// Shared definitions for the 3x3 window generator.
//   PIX_W_DEF  - default pixel width
//   pixel_t    - default-width pixel type
//   WIN_TAPS   - number of window taps (3x3)
//   cnt_width  - counter width for a modulo-n counter (clog2, minimum 1)
package window_gen_3x3_pkg;

  localparam int unsigned PIX_W_DEF = 8;
  localparam int unsigned WIN_TAPS  = 9;

  typedef logic [PIX_W_DEF-1:0] pixel_t;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/window_gen_3x3_line_buffer.sv
// One image line of pixel storage for the 3x3 window generator.
// Single port, asynchronous read, synchronous write. A write returns the
// old contents on rdata_o during the same cycle (read-before-write).
// Ports:
//   clk_i   - clock
//   we_i    - write enable
//   addr_i  - column address
//   wdata_i - pixel to store
//   rdata_o - pixel currently stored at addr_i
module window_line_buffer
  import window_gen_3x3_pkg::*;
#(
  parameter int unsigned Depth = 320,
  parameter int unsigned Width = PIX_W_DEF,
  parameter int unsigned AddrW = cnt_width(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o
);

  // Contents are deliberately not reset.
  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/window_gen_3x3.sv
// Streaming 3x3 neighbourhood generator for a raster pixel stream.
// Two line buffers hold the previous two lines; a 3x3 register window shifts
// left on every accepted pixel. Only fully-interior windows are flagged valid.
// Ports:
//   clk_i, rst_i         - clock, asynchronous active-high reset
//   pix_i, pix_valid_i   - input pixel and its qualifier
//   sof_i                - start of frame (qualified by pix_valid_i)
//   win0_o..win8_o       - window, row-major, win0 top-left, win8 newest pixel
//   win_valid_o          - one-cycle pulse per interior window
//   frame_done_o         - pulses with the last window of a frame
//   win_x_o, win_y_o     - centre coordinate of the window; present only when
//                          WINDOW_GEN_POS_OUT_EN is defined
module window_gen_3x3
  import window_gen_3x3_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 320,
  parameter int unsigned IMG_HEIGHT = 240,
  parameter int unsigned PIX_W      = PIX_W_DEF,
  localparam int unsigned ColW      = cnt_width(IMG_WIDTH),
  localparam int unsigned RowW      = cnt_width(IMG_HEIGHT)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [PIX_W-1:0] pix_i,
  input  logic             pix_valid_i,
  input  logic             sof_i,
  output logic [PIX_W-1:0] win0_o,
  output logic [PIX_W-1:0] win1_o,
  output logic [PIX_W-1:0] win2_o,
  output logic [PIX_W-1:0] win3_o,
  output logic [PIX_W-1:0] win4_o,
  output logic [PIX_W-1:0] win5_o,
  output logic [PIX_W-1:0] win6_o,
  output logic [PIX_W-1:0] win7_o,
  output logic [PIX_W-1:0] win8_o,
`ifdef WINDOW_GEN_POS_OUT_EN
  output logic [ColW-1:0]  win_x_o,
  output logic [RowW-1:0]  win_y_o,
`endif
  output logic             win_valid_o,
  output logic             frame_done_o
);

  localparam logic [ColW-1:0] ColLast = ColW'(IMG_WIDTH - 1);
  localparam logic [ColW-1:0] ColTwo  = ColW'(2);
  localparam logic [RowW-1:0] RowLast = RowW'(IMG_HEIGHT - 1);
  localparam logic [RowW-1:0] RowTwo  = RowW'(2);
`ifdef WINDOW_GEN_POS_OUT_EN
  localparam logic [ColW-1:0] ColOne  = ColW'(1);
  localparam logic [RowW-1:0] RowOne  = RowW'(1);
`endif

  logic [ColW-1:0]  col_q, col_d, col_eff;
  logic [RowW-1:0]  row_q, row_d, row_eff;
  logic [PIX_W-1:0] win_q [WIN_TAPS];
  logic [PIX_W-1:0] win_d [WIN_TAPS];
  logic             win_valid_q, win_valid_d;
  logic             frame_done_q, frame_done_d;
  logic [PIX_W-1:0] top_px, mid_px;
  logic             restart;
  logic             interior;

  // sof forces the accepted pixel to (0,0) whatever the counters say.
  assign restart  = pix_valid_i & sof_i;
  assign col_eff  = restart ? '0 : col_q;
  assign row_eff  = restart ? '0 : row_q;
  assign interior = (row_eff >= RowTwo) && (col_eff >= ColTwo);

  // lb0 holds line r-2, lb1 holds line r-1; each accept ages the column by one line.
  window_line_buffer #(
    .Depth (IMG_WIDTH),
    .Width (PIX_W),
    .AddrW (ColW)
  ) u_lb0 (
    .clk_i   (clk_i),
    .we_i    (pix_valid_i),
    .addr_i  (col_eff),
    .wdata_i (mid_px),
    .rdata_o (top_px)
  );

  window_line_buffer #(
    .Depth (IMG_WIDTH),
    .Width (PIX_W),
    .AddrW (ColW)
  ) u_lb1 (
    .clk_i   (clk_i),
    .we_i    (pix_valid_i),
    .addr_i  (col_eff),
    .wdata_i (pix_i),
    .rdata_o (mid_px)
  );

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    win_d        = win_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    if (pix_valid_i) begin
      if (col_eff == ColLast) begin
        col_d = '0;
        row_d = (row_eff == RowLast) ? '0 : row_eff + 1'b1;
      end else begin
        col_d = col_eff + 1'b1;
        row_d = row_eff;
      end
      for (int r = 0; r < 3; r++) begin
        win_d[3*r]     = win_q[3*r+1];
        win_d[3*r + 1] = win_q[3*r+2];
      end
      win_d[2]     = top_px;
      win_d[5]     = mid_px;
      win_d[8]     = pix_i;
      win_valid_d  = interior;
      frame_done_d = (row_eff == RowLast) && (col_eff == ColLast);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      col_q        <= '0;
      row_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < WIN_TAPS; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      win_q        <= win_d;
    end
  end

`ifdef WINDOW_GEN_POS_OUT_EN
  logic [ColW-1:0] win_x_q, win_x_d;
  logic [RowW-1:0] win_y_q, win_y_d;

  always_comb begin
    win_x_d = win_x_q;
    win_y_d = win_y_q;
    if (pix_valid_i && interior) begin
      win_x_d = col_eff - ColOne;
      win_y_d = row_eff - RowOne;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      win_x_q <= '0;
      win_y_q <= '0;
    end else begin
      win_x_q <= win_x_d;
      win_y_q <= win_y_d;
    end
  end

  assign win_x_o = win_x_q;
  assign win_y_o = win_y_q;
`endif

  assign win0_o       = win_q[0];
  assign win1_o       = win_q[1];
  assign win2_o       = win_q[2];
  assign win3_o       = win_q[3];
  assign win4_o       = win_q[4];
  assign win5_o       = win_q[5];
  assign win6_o       = win_q[6];
  assign win7_o       = win_q[7];
  assign win8_o       = win_q[8];
  assign win_valid_o  = win_valid_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_window_gen_3x3.sv
// Bench for window_gen_3x3 with a 5x4 image, pixel = base + row*16 + col.
// Expected windows are pushed when a pixel is driven and popped when the
// DUT pulses win_valid_o.
module tb_window_gen_3x3;

  localparam int W = 5;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pix = '0;
  logic       pix_valid = 1'b0;
  logic       sof = 1'b0;
  logic [7:0] win0, win1, win2, win3, win4, win5, win6, win7, win8;
  logic       win_valid, frame_done;
`ifdef WINDOW_GEN_POS_OUT_EN
  logic [2:0] win_x;
  logic [1:0] win_y;
`endif

  window_gen_3x3 #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .PIX_W      (8)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .pix_i        (pix),
    .pix_valid_i  (pix_valid),
    .sof_i        (sof),
    .win0_o       (win0),
    .win1_o       (win1),
    .win2_o       (win2),
    .win3_o       (win3),
    .win4_o       (win4),
    .win5_o       (win5),
    .win6_o       (win6),
    .win7_o       (win7),
    .win8_o       (win8),
`ifdef WINDOW_GEN_POS_OUT_EN
    .win_x_o      (win_x),
    .win_y_o      (win_y),
`endif
    .win_valid_o  (win_valid),
    .frame_done_o (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [71:0] win;
    logic        fd;
    int          x;
    int          y;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   win_cnt  = 0;
  int   fd_cnt   = 0;
  logic acc_seen = 1'b0;

  function automatic logic [7:0] pixval(input logic [7:0] base, input int r, input int c);
    return base + 8'(r * 16 + c);
  endfunction

  always @(posedge clk) acc_seen <= pix_valid && !rst;

  // Scoreboard: compare every window the DUT presents.
  always @(negedge clk) begin
    if (!rst && win_valid) begin
      n_checks++;
      if (!acc_seen) begin
        n_fail++;
        $display("FAIL valid_without_accept: win_valid=1 required 0");
      end
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_window: got %h, none expected",
                 {win0, win1, win2, win3, win4, win5, win6, win7, win8});
      end else begin
        mon_e = sb.pop_front();
        if ({win0, win1, win2, win3, win4, win5, win6, win7, win8} !== mon_e.win) begin
          n_fail++;
          $display("FAIL window: got %h required %h",
                   {win0, win1, win2, win3, win4, win5, win6, win7, win8}, mon_e.win);
        end
        n_checks++;
        if (frame_done !== mon_e.fd) begin
          n_fail++;
          $display("FAIL frame_done: got %b required %b", frame_done, mon_e.fd);
        end
`ifdef WINDOW_GEN_POS_OUT_EN
        n_checks++;
        if (int'(win_x) != mon_e.x || int'(win_y) != mon_e.y) begin
          n_fail++;
          $display("FAIL position: got (%0d,%0d) required (%0d,%0d)",
                   win_x, win_y, mon_e.x, mon_e.y);
        end
`endif
      end
      win_cnt++;
      if (frame_done) fd_cnt++;
    end else if (!rst && frame_done) begin
      n_checks++;
      n_fail++;
      $display("FAIL frame_done_without_valid: frame_done=1 required 0");
    end
  end

  // Drive one pixel at bench coordinate (r,c); returns at posedge+1 after the accept.
  task automatic send_px(input logic [7:0] base, input int r, input int c, input bit s);
    exp_t e;
    pix       = pixval(base, r, c);
    sof       = s;
    pix_valid = 1'b1;
    if (r >= 2 && c >= 2) begin
      for (int k = 0; k < 9; k++) begin
        e.win[(8 - k) * 8 +: 8] = pixval(base, r - 2 + k / 3, c - 2 + k % 3);
      end
      e.fd = (r == H - 1) && (c == W - 1);
      e.x  = c - 1;
      e.y  = r - 1;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    sof       = 1'b0;
  endtask

  // Idle cycles: the window must hold and win_valid must stay low.
  task automatic gap(input int g);
    logic [7:0] held;
    for (int i = 0; i < g; i++) begin
      held = win8;
      @(posedge clk);
      #1;
      n_checks++;
      if (win8 !== held || win_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL gap_hold: win8=%h valid=%b required win8=%h valid=0",
                 win8, win_valid, held);
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] base, input int max_gap, input int npix,
                            input bit use_sof);
    for (int idx = 0; idx < npix; idx++) begin
      send_px(base, idx / W, idx % W, use_sof && (idx == 0));
      if (max_gap > 0) gap(int'($urandom_range(max_gap, 0)));
    end
  endtask

  task automatic drain_and_check(input string name, input int w0, input int f0,
                                 input int nwin, input int nfd);
    @(negedge clk);
    #1;
    n_checks++;
    if (win_cnt - w0 != nwin) begin
      n_fail++;
      $display("FAIL %s_window_count: got %0d required %0d", name, win_cnt - w0, nwin);
    end
    n_checks++;
    if (fd_cnt - f0 != nfd) begin
      n_fail++;
      $display("FAIL %s_frame_done_count: got %0d required %0d", name, fd_cnt - f0, nfd);
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_pending: %0d windows never produced, required 0", name, sb.size());
    end
  endtask

  task automatic check_zero(input string name);
    n_checks++;
    if ({win0, win1, win2, win3, win4, win5, win6, win7, win8} !== 72'h0) begin
      n_fail++;
      $display("FAIL %s_window: got %h required 0", name,
               {win0, win1, win2, win3, win4, win5, win6, win7, win8});
    end
    n_checks++;
    if (win_valid !== 1'b0 || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_flags: valid=%b done=%b required 0 0", name, win_valid, frame_done);
    end
  endtask

  task automatic test_reset;
    #2;
    check_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_continuous;
    int w0 = win_cnt;
    int f0 = fd_cnt;
    send_frame(8'h00, 0, W * H, 1'b1);
    drain_and_check("continuous", w0, f0, 6, 1);
  endtask

  task automatic test_gaps;
    int w0 = win_cnt;
    int f0 = fd_cnt;
    send_frame(8'h00, 3, W * H, 1'b1);
    drain_and_check("gaps", w0, f0, 6, 1);
  endtask

  task automatic test_back_to_back;
    int w0 = win_cnt;
    int f0 = fd_cnt;
    send_frame(8'h00, 0, W * H, 1'b1);
    send_frame(8'h80, 0, W * H, 1'b1);
    drain_and_check("back_to_back", w0, f0, 12, 2);
  endtask

  task automatic test_sof_abort;
    int w0 = win_cnt;
    int f0 = fd_cnt;
    // Frame 1 stops after (2,2); sof restarts where (2,3) would have been.
    send_frame(8'h00, 0, 2 * W + 3, 1'b1);
    send_frame(8'h00, 0, W * H, 1'b1);
    drain_and_check("sof_abort", w0, f0, 7, 1);
  endtask

  task automatic test_reset_mid;
    int w0;
    int f0;
    send_frame(8'h00, 0, 2 * W + 3, 1'b1);
    n_checks++;
    if (win_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_valid: got %b required 1", win_valid);
    end
    #1;
    rst = 1'b1;
    #1;
    check_zero("async_reset");
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    w0 = win_cnt;
    f0 = fd_cnt;
    // No sof: the first pixel after reset must be taken as (0,0).
    send_frame(8'h00, 0, W * H, 1'b0);
    drain_and_check("after_reset", w0, f0, 6, 1);
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_gaps();
    test_back_to_back();
    test_sof_abort();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
